varredura_display_bcd: RTL and testbench
========================================

Name: varredura_display_bcd

Overview:
- Downstream consumer of the 3-digit BCD converter output (centenas/dezenas/unidades).
- Latches a BCD triple on a load strobe and time-multiplexes it onto a shared 3-digit 7-segment display.
- Scans the digits with a refresh counter and applies optional leading-zero blanking.
- Inserts a one-cycle anti-ghosting blank at every digit change.

Parameters:
- DIVISOR, 50000, clock cycles per digit slot; legal range 2..2^20.
- SEG_ATIVO_BAIXO, 1, 1 = segment outputs active-low (common anode); 0 = active-high.
- DIG_ATIVO_BAIXO, 1, 1 = digit-select outputs active-low; 0 = active-high.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- carregar  input  1  load strobe; the BCD inputs are captured on every clock edge where this is 1.
- bcd_centenas  input  4  hundreds digit.
- bcd_dezenas  input  4  tens digit.
- bcd_unidades  input  4  units digit.
- apagar_zeros  input  1  1 = blank leading zeros; sampled live, not latched.
- segmentos  output  7  segment drive, bit order [6:0] = g f e d c b a.
- selecao_digito  output  3  digit enable, one-hot; bit0 = units, bit1 = tens, bit2 = hundreds.
- carregado  output  1  one-cycle pulse, asserted the cycle after a capture.

Behaviour:
- Reset (async, active-high): all internal and output state clears immediately.
  - Shadow register = 000.
  - Refresh counter = 0.
  - Slot = UNIDADES.
  - Guard flag = 1.
  - segmentos = all off (polarity-correct).
  - selecao_digito = none enabled.
  - carregado = 0.
- Capture: at an edge with carregar = 1, the shadow register takes all three input digits; carregado = 1 for exactly the following cycle.
  - Back-to-back strobes capture every cycle; carregado stays high.
  - Inputs are ignored while carregar = 0.
- Refresh counter: 0..DIVISOR-1, increments every cycle. At DIVISOR-1 it wraps to 0 and the slot advances.
- Slot FSM: UNIDADES -> DEZENAS -> CENTENAS -> UNIDADES. No other transitions; no idle state.
- Guard: in the first cycle of each slot (counter = 0), including the first cycle after reset release:
  - segmentos = all off;
  - selecao_digito = none.
- Non-guard cycles: selecao_digito enables the current slot's digit only; segmentos show the decoded shadow digit for that slot.
- Outputs are registered: they reflect slot/counter/shadow state of the previous edge.
  - Latency from a carregar edge to the new value on segmentos is 2 cycles, provided the display cycle is not a guard cycle.
- Decode (active-high form, g..a):
  - 0 = 0111111, 1 = 0000110, 2 = 1011011, 3 = 1001111, 4 = 1100110
  - 5 = 1101101, 6 = 1111101, 7 = 0000111, 8 = 1111111, 9 = 1101111
  - Digit codes 10..15 display 1000000 (dash).
  - If SEG_ATIVO_BAIXO = 1, the value is bitwise inverted. If DIG_ATIVO_BAIXO = 1, selecao_digito is inverted (an inactive digit reads 1).
- Leading-zero blanking, when apagar_zeros = 1:
  - hundreds blank if C = 0;
  - tens blank if C = 0 and D = 0;
  - units never blank.
  - A blank digit still gets its selecao_digito enable; its segments are all off.
  - Invalid codes (10..15) are never treated as zero.
- Simultaneous events:
  - Capture coinciding with a slot change: the new slot displays the new shadow value after the guard cycle.
  - apagar_zeros toggling mid-slot takes effect on the next registered output.
- Reset mid-slot: outputs blank immediately, independent of the clock. After release the scan restarts at UNIDADES with a guard cycle; the previously latched value is lost.
- Counter width = ceil(log2(DIVISOR)). No overflow beyond DIVISOR-1 is possible.

Test Plan:
- Reset then release, DIVISOR = 4, SEG_ATIVO_BAIXO = 1, DIG_ATIVO_BAIXO = 1, no load:
  - first cycle after release: segmentos = 1111111, selecao_digito = 111 (guard);
  - next 3 cycles: selecao_digito = 110, segmentos = 1000000 ("0");
  - then guard, then selecao_digito = 101 showing "0".
- Load 2/5/5 (C/D/U) for one cycle -> carregado = 1 the next cycle only. Over one 12-cycle scan, in non-guard cycles:
  - units = 0010010;
  - tens = 0010010;
  - hundreds = 0100100 (active-low).
- apagar_zeros = 1, load 0/0/7:
  - units = 1111000;
  - tens and hundreds segments = 1111111, with their selects still asserted in their slots.
  - Load 0/4/0: tens = 0011001, hundreds blank, units = 1000000.
- Load invalid 0/12/15 with apagar_zeros = 1 -> tens and units show dash 0111111, hundreds blank.
- Capture at the counter-wrap edge -> the following slot shows the new digit right after its single guard cycle; no cycle shows a mixed old/new value on a non-guard cycle.
- Assert reset mid-slot while displaying "8" -> segmentos go to 1111111 and selecao_digito to 111 before the next clock edge. After release the scan restarts at UNIDADES showing "0".

Source files
------------

// File: rtl/varredura_display_bcd.sv
`default_nettype none
// ============================================================================
//  Module      : varredura_display_bcd
//  Description : Latches a 3-digit BCD value (hundreds/tens/units) on a load
//                strobe and time-multiplexes it onto a shared 3-digit
//                7-segment display. Each digit owns a slot of DIVISOR clock
//                cycles. The first cycle of every slot is a blank guard
//                cycle that suppresses ghosting while the digit select
//                changes. Optional leading-zero blanking is supported.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DIVISOR          clock cycles per digit slot (2 .. 2**20)
//    SEG_ATIVO_BAIXO  1 = segment outputs active-low, 0 = active-high
//    DIG_ATIVO_BAIXO  1 = digit selects active-low,   0 = active-high
//  Ports
//    clock            in   1  system clock, rising edge
//    reset            in   1  asynchronous active-high reset
//    carregar         in   1  load strobe, BCD inputs captured while 1
//    bcd_centenas     in   4  hundreds digit
//    bcd_dezenas      in   4  tens digit
//    bcd_unidades     in   4  units digit
//    apagar_zeros     in   1  1 = blank leading zeros (sampled live)
//    segmentos        out  7  segment drive, [6:0] = g f e d c b a
//    selecao_digito   out  3  one-hot digit enable, bit0 units .. bit2 hundreds
//    carregado        out  1  one-cycle pulse the cycle after a capture
// ============================================================================
module varredura_display_bcd #(
   parameter int unsigned DIVISOR         = 50000,
   parameter bit          SEG_ATIVO_BAIXO = 1'b1,
   parameter bit          DIG_ATIVO_BAIXO = 1'b1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       carregar,
   input  logic [3:0] bcd_centenas,
   input  logic [3:0] bcd_dezenas,
   input  logic [3:0] bcd_unidades,
   input  logic       apagar_zeros,
   output logic [6:0] segmentos,
   output logic [2:0] selecao_digito,
   output logic       carregado
);

   // ------------------------------------------------------------------------
   // Constants
   // ------------------------------------------------------------------------
   localparam int unsigned     CNT_W   = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIVISOR - 1);

   // Polarity-correct "everything off" codes for the two output buses.
   localparam logic [6:0] SEG_OFF = SEG_ATIVO_BAIXO ? 7'b111_1111 : 7'b000_0000;
   localparam logic [2:0] SEL_OFF = DIG_ATIVO_BAIXO ? 3'b111 : 3'b000;

   // Scan slots; the encoding doubles as the digit index (0 = units).
   typedef enum logic [1:0] {
      SLOT_UNIDADES = 2'd0,
      SLOT_DEZENAS  = 2'd1,
      SLOT_CENTENAS = 2'd2
   } slot_t;

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [3:0]       cent_q, cent_d;
   logic [3:0]       dez_q,  dez_d;
   logic [3:0]       uni_q,  uni_d;
   logic [CNT_W-1:0] cnt_q,  cnt_d;
   slot_t            slot_q, slot_d;
   logic             guard_q, guard_d;
   logic [6:0]       seg_q,  seg_d;
   logic [2:0]       sel_q,  sel_d;
   logic             carregado_q, carregado_d;

   // ------------------------------------------------------------------------
   // Active-high g..a decode. Codes 10..15 render as a dash.
   // ------------------------------------------------------------------------
   function automatic logic [6:0] decode_bcd(input logic [3:0] digito);
      logic [6:0] padrao;
      case (digito)
         4'd0:    padrao = 7'b011_1111;
         4'd1:    padrao = 7'b000_0110;
         4'd2:    padrao = 7'b101_1011;
         4'd3:    padrao = 7'b100_1111;
         4'd4:    padrao = 7'b110_0110;
         4'd5:    padrao = 7'b110_1101;
         4'd6:    padrao = 7'b111_1101;
         4'd7:    padrao = 7'b000_0111;
         4'd8:    padrao = 7'b111_1111;
         4'd9:    padrao = 7'b110_1111;
         default: padrao = 7'b100_0000;
      endcase
      return padrao;
   endfunction

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cent_q      <= 4'd0;
         dez_q       <= 4'd0;
         uni_q       <= 4'd0;
         cnt_q       <= '0;
         slot_q      <= SLOT_UNIDADES;
         guard_q     <= 1'b1;
         seg_q       <= SEG_OFF;
         sel_q       <= SEL_OFF;
         carregado_q <= 1'b0;
      end else begin
         cent_q      <= cent_d;
         dez_q       <= dez_d;
         uni_q       <= uni_d;
         cnt_q       <= cnt_d;
         slot_q      <= slot_d;
         guard_q     <= guard_d;
         seg_q       <= seg_d;
         sel_q       <= sel_d;
         carregado_q <= carregado_d;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state and registered-output logic
   // ------------------------------------------------------------------------
   logic       w_wrap;
   logic [3:0] w_digito;
   logic       w_apagado;
   logic [2:0] w_sel_ativo;

   always_comb begin
      // Defaults: hold state.
      cent_d      = cent_q;
      dez_d       = dez_q;
      uni_d       = uni_q;
      cnt_d       = cnt_q;
      slot_d      = slot_q;
      guard_d     = guard_q;
      seg_d       = SEG_OFF;
      sel_d       = SEL_OFF;
      carregado_d = carregar;
      w_wrap      = 1'b0;
      w_digito    = 4'd0;
      w_apagado   = 1'b0;
      w_sel_ativo = 3'b000;

      // Shadow capture.
      if (carregar) begin
         cent_d = bcd_centenas;
         dez_d  = bcd_dezenas;
         uni_d  = bcd_unidades;
      end

      // Refresh counter and slot sequencing.
      w_wrap = (cnt_q == CNT_MAX);
      if (w_wrap) begin
         cnt_d = '0;
         case (slot_q)
            SLOT_UNIDADES: slot_d = SLOT_DEZENAS;
            SLOT_DEZENAS:  slot_d = SLOT_CENTENAS;
            SLOT_CENTENAS: slot_d = SLOT_UNIDADES;
            default:       slot_d = SLOT_UNIDADES;
         endcase
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
      // The guard flag marks a counter value of 0, i.e. the cycle after a wrap.
      guard_d = w_wrap;

      // Digit for the current slot, with leading-zero blanking. Only a real
      // zero code counts as zero, so invalid codes are never blanked.
      case (slot_q)
         SLOT_UNIDADES: begin
            w_digito    = uni_q;
            w_sel_ativo = 3'b001;
            w_apagado   = 1'b0;
         end
         SLOT_DEZENAS: begin
            w_digito    = dez_q;
            w_sel_ativo = 3'b010;
            w_apagado   = apagar_zeros && (cent_q == 4'd0) && (dez_q == 4'd0);
         end
         SLOT_CENTENAS: begin
            w_digito    = cent_q;
            w_sel_ativo = 3'b100;
            w_apagado   = apagar_zeros && (cent_q == 4'd0);
         end
         default: begin
            w_digito    = 4'd0;
            w_sel_ativo = 3'b000;
            w_apagado   = 1'b1;
         end
      endcase

      // Guard cycles keep both buses off; otherwise the slot's digit is
      // enabled even when its segments are blanked.
      if (!guard_q) begin
         sel_d = w_sel_ativo ^ {3{DIG_ATIVO_BAIXO}};
         if (!w_apagado) begin
            seg_d = decode_bcd(w_digito) ^ {7{SEG_ATIVO_BAIXO}};
         end
      end
   end

   assign segmentos      = seg_q;
   assign selecao_digito = sel_q;
   assign carregado      = carregado_q;

endmodule
`default_nettype wire

// File: tb/tb_varredura_display_bcd.sv
`default_nettype none
// ============================================================================
//  Module      : tb_varredura_display_bcd
//  Description : Self-checking bench for varredura_display_bcd (DIVISOR = 4,
//                active-low segments and selects). Expected outputs come from
//                a cycle-index model: the n-th edge after reset release shows
//                slot (n / DIVISOR) % 3, with phase n % DIVISOR == 0 blank.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_varredura_display_bcd;

   localparam int DIV = 4;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       carregar = 1'b0;
   logic [3:0] bcd_centenas = 4'd0;
   logic [3:0] bcd_dezenas = 4'd0;
   logic [3:0] bcd_unidades = 4'd0;
   logic       apagar_zeros = 1'b0;
   logic [6:0] segmentos;
   logic [2:0] selecao_digito;
   logic       carregado;

   int checks = 0;
   int errors = 0;

   // Reference model state
   int         cyc;
   logic [3:0] m_c, m_d, m_u;
   logic [6:0] exp_seg;
   logic [2:0] exp_sel;
   logic       exp_ld;

   varredura_display_bcd #(
      .DIVISOR        (DIV),
      .SEG_ATIVO_BAIXO(1'b1),
      .DIG_ATIVO_BAIXO(1'b1)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .carregar      (carregar),
      .bcd_centenas  (bcd_centenas),
      .bcd_dezenas   (bcd_dezenas),
      .bcd_unidades  (bcd_unidades),
      .apagar_zeros  (apagar_zeros),
      .segmentos     (segmentos),
      .selecao_digito(selecao_digito),
      .carregado     (carregado)
   );

   always #5 clock = ~clock;

   function automatic logic [6:0] seg_ah(input logic [3:0] v);
      case (v)
         4'd0: return 7'b0111111;
         4'd1: return 7'b0000110;
         4'd2: return 7'b1011011;
         4'd3: return 7'b1001111;
         4'd4: return 7'b1100110;
         4'd5: return 7'b1101101;
         4'd6: return 7'b1111101;
         4'd7: return 7'b0000111;
         4'd8: return 7'b1111111;
         4'd9: return 7'b1101111;
         default: return 7'b1000000;
      endcase
   endfunction

   task automatic chk7(input string tag, input logic [6:0] obs, input logic [6:0] exp_v);
      checks++;
      assert (obs === exp_v)
      else begin
         errors++;
         $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp_v);
      end
   endtask

   task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] exp_v);
      checks++;
      assert (obs === exp_v)
      else begin
         errors++;
         $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp_v);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp_v);
      checks++;
      assert (obs === exp_v)
      else begin
         errors++;
         $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp_v);
      end
   endtask

   // One clock: model evaluates the pre-edge state at the rising edge, the
   // DUT outputs are compared on the following falling edge.
   task automatic tick();
      int         phase, slot;
      logic [3:0] dig;
      logic       blank;
      @(posedge clock);
      phase = cyc % DIV;
      slot  = (cyc / DIV) % 3;
      if (phase == 0) begin
         exp_seg = 7'b1111111;
         exp_sel = 3'b111;
      end else begin
         dig   = (slot == 0) ? m_u : (slot == 1) ? m_d : m_c;
         blank = apagar_zeros &&
                 (((slot == 2) && (m_c == 4'd0)) ||
                  ((slot == 1) && (m_c == 4'd0) && (m_d == 4'd0)));
         exp_sel = ~(3'b001 << slot);
         exp_seg = blank ? 7'b1111111 : ~seg_ah(dig);
      end
      exp_ld = carregar;
      if (carregar) begin
         m_c = bcd_centenas;
         m_d = bcd_dezenas;
         m_u = bcd_unidades;
      end
      cyc++;
      @(negedge clock);
      chk7("segmentos", segmentos, exp_seg);
      chk3("selecao", selecao_digito, exp_sel);
      chk1("carregado", carregado, exp_ld);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic load(input logic [3:0] c, input logic [3:0] d, input logic [3:0] u);
      bcd_centenas = c;
      bcd_dezenas  = d;
      bcd_unidades = u;
      carregar     = 1'b1;
      tick();
      carregar     = 1'b0;
      bcd_centenas = 4'($urandom_range(0, 15));
      bcd_dezenas  = 4'($urandom_range(0, 15));
      bcd_unidades = 4'($urandom_range(0, 15));
   endtask

   initial begin
      cyc = 0;
      m_c = 4'd0; m_d = 4'd0; m_u = 4'd0;

      // Reset state
      #12;
      chk7("rst_seg", segmentos, 7'b1111111);
      chk3("rst_sel", selecao_digito, 3'b111);
      chk1("rst_ld", carregado, 1'b0);
      @(negedge clock);
      reset = 1'b0;

      // Idle scan showing 000
      ticks(12);

      // 2/5/5
      load(4'd2, 4'd5, 4'd5);
      ticks(12);

      // Leading-zero blanking and invalid codes
      apagar_zeros = 1'b1;
      load(4'd0, 4'd0, 4'd7);
      ticks(12);
      load(4'd0, 4'd4, 4'd0);
      ticks(12);
      load(4'd0, 4'd12, 4'd15);
      ticks(12);

      // Capture on the counter-wrap edge
      apagar_zeros = 1'b0;
      while ((cyc % DIV) != DIV - 1) tick();
      load(4'd8, 4'd8, 4'd8);
      ticks(6);

      // Reset mid-slot while showing "8"
      while ((cyc % DIV) == 0) tick();
      chk7("pre_rst_seg", segmentos, 7'b0000000);
      #1 reset = 1'b1;
      #1;
      chk7("async_rst_seg", segmentos, 7'b1111111);
      chk3("async_rst_sel", selecao_digito, 3'b111);
      chk1("async_rst_ld", carregado, 1'b0);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      cyc = 0;
      m_c = 4'd0; m_d = 4'd0; m_u = 4'd0;
      ticks(8);

      // Randomized traffic
      for (int i = 0; i < 300; i++) begin
         carregar     = ($urandom_range(0, 3) == 0);
         bcd_centenas = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
         bcd_dezenas  = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
         bcd_unidades = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 7) == 0) apagar_zeros = ~apagar_zeros;
         tick();
      end
      carregar = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
